// File: rtl/bullet_pool_pkg.sv
// Shared playfield constants for the plane, enemy and bullet blocks.
// Bullet pool defaults live here so every instantiating block agrees on them.
package bullet_pool_pkg;

    localparam int COORD_W_DEF   = 10;
    localparam int SCREEN_H      = 640;
    localparam int SCREEN_V      = 480;
    localparam int TOP_LIMIT_DEF = 1;

    localparam int N_BULLETS_DEF = 4;
    localparam int MOVE_DIV_DEF  = 1;
    localparam int STEP_DEF      = 1;
    localparam int COOLDOWN_DEF  = 16;

    typedef enum logic [1:0] {
        SLOT_HOLD,
        SLOT_LAUNCH,
        SLOT_MOVE,
        SLOT_TRACK
    } slot_action_e;

endpackage

// File: rtl/bullet_pool_if.sv
// Bundle of the bullet pool's game-side signals: plane position, fire key,
// collision hits in; per-slot coordinates, active mask and launch pulse out.
interface bullet_pool_if #(
    parameter int N_BULLETS = 4,
    parameter int COORD_W   = 10
);
    logic [COORD_W-1:0]           h_my_plane;
    logic [COORD_W-1:0]           v_my_plane;
    logic                         fire;
    logic [N_BULLETS-1:0]         hit;
    logic [N_BULLETS*COORD_W-1:0] h_bullet;
    logic [N_BULLETS*COORD_W-1:0] v_bullet;
    logic [N_BULLETS-1:0]         active;
    logic                         shot_fired;

    modport master (
        output h_my_plane, v_my_plane, fire, hit,
        input  h_bullet, v_bullet, active, shot_fired
    );

    modport slave (
        input  h_my_plane, v_my_plane, fire, hit,
        output h_bullet, v_bullet, active, shot_fired
    );

endinterface

// File: rtl/bullet_pool_slot.sv
// One shot slot: position registers plus the hit > launch > move > track priority.
// An idle slot shadows the plane so a launch never shows a stale position.
module bullet_pool_slot
    import bullet_pool_pkg::*;
#(
    parameter int COORD_W   = 10,
    parameter int STEP      = 1,
    parameter int TOP_LIMIT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               launch_i,
    input  logic               hit_i,
    input  logic               move_tick_i,
    input  logic [COORD_W-1:0] h_plane_i,
    input  logic [COORD_W-1:0] v_plane_i,
    output logic [COORD_W-1:0] h_o,
    output logic [COORD_W-1:0] v_o,
    output logic               active_o
);

    // One extra bit keeps TOP_LIMIT+STEP from wrapping near the coordinate ceiling.
    localparam logic [COORD_W:0] RETIRE_LIM = (COORD_W+1)'(TOP_LIMIT + STEP);
    localparam logic [COORD_W-1:0] STEP_C   = COORD_W'(STEP);

    logic [COORD_W-1:0] h_q, h_d;
    logic [COORD_W-1:0] v_q, v_d;
    logic               active_q, active_d;
    slot_action_e       action;
    logic               at_top;

    always_comb begin
        at_top = ({1'b0, v_q} < RETIRE_LIM);
        action = SLOT_HOLD;
        if (hit_i && active_q) begin
            action = SLOT_HOLD;
        end else if (launch_i) begin
            action = SLOT_LAUNCH;
        end else if (active_q && move_tick_i) begin
            action = SLOT_MOVE;
        end else if (!active_q) begin
            action = SLOT_TRACK;
        end
    end

    always_comb begin
        h_d      = h_q;
        v_d      = v_q;
        active_d = active_q;
        unique case (action)
            SLOT_HOLD: begin
                if (hit_i && active_q) begin
                    active_d = 1'b0;
                end
            end
            SLOT_LAUNCH: begin
                h_d      = h_plane_i;
                v_d      = v_plane_i;
                active_d = 1'b1;
            end
            SLOT_MOVE: begin
                if (at_top) begin
                    active_d = 1'b0;
                end else begin
                    v_d = v_q - STEP_C;
                end
            end
            SLOT_TRACK: begin
                h_d = h_plane_i;
                v_d = v_plane_i;
            end
            default: begin
                active_d = active_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q      <= '0;
            v_q      <= '0;
            active_q <= 1'b0;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            active_q <= active_d;
        end
    end

    assign h_o      = h_q;
    assign v_o      = v_q;
    assign active_o = active_q;

endmodule

// File: rtl/bullet_pool.sv
// Player bullet manager: fire edge detect, reload cooldown, movement divider and
// lowest-free slot allocation over N_BULLETS independent shot slots.
module bullet_pool
    import bullet_pool_pkg::*;
#(
    parameter int N_BULLETS = N_BULLETS_DEF,
    parameter int COORD_W   = COORD_W_DEF,
    parameter int MOVE_DIV  = MOVE_DIV_DEF,
    parameter int STEP      = STEP_DEF,
    parameter int TOP_LIMIT = TOP_LIMIT_DEF,
    parameter int COOLDOWN  = COOLDOWN_DEF
) (
    input  logic          clk,
    input  logic          rst,
    bullet_pool_if.slave  bus
);

    localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam int DIV_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

    logic                 fire_q;
    logic [CD_W-1:0]      cd_q, cd_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic                 shot_q, shot_d;

    logic                 fire_edge;
    logic                 cd_idle;
    logic                 accept;
    logic                 move_tick;
    logic [N_BULLETS-1:0] active_w;
    logic [N_BULLETS-1:0] free_w;
    logic [N_BULLETS-1:0] first_free;
    logic [N_BULLETS-1:0] launch_sel;

    logic [N_BULLETS*COORD_W-1:0] h_w;
    logic [N_BULLETS*COORD_W-1:0] v_w;

    // Free slots come from the registered mask, so a slot hit this cycle
    // only becomes allocatable once its active bit has actually dropped.
    always_comb begin
        free_w     = ~active_w;
        first_free = '0;
        for (int i = N_BULLETS - 1; i >= 0; i--) begin
            if (free_w[i]) begin
                first_free    = '0;
                first_free[i] = 1'b1;
            end
        end
    end

    always_comb begin
        fire_edge  = bus.fire & ~fire_q;
        cd_idle    = (cd_q == '0);
        accept     = fire_edge & cd_idle & (|free_w);
        launch_sel = accept ? first_free : '0;
        shot_d     = accept;

        if (accept) begin
            cd_d = CD_W'(COOLDOWN);
        end else if (!cd_idle) begin
            cd_d = cd_q - 1'b1;
        end else begin
            cd_d = cd_q;
        end

        move_tick = (div_q == DIV_W'(MOVE_DIV - 1));
        div_d     = move_tick ? '0 : div_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fire_q <= 1'b0;
            cd_q   <= '0;
            div_q  <= '0;
            shot_q <= 1'b0;
        end else begin
            fire_q <= bus.fire;
            cd_q   <= cd_d;
            div_q  <= div_d;
            shot_q <= shot_d;
        end
    end

    for (genvar g = 0; g < N_BULLETS; g++) begin : g_slot
        bullet_pool_slot #(
            .COORD_W   (COORD_W),
            .STEP      (STEP),
            .TOP_LIMIT (TOP_LIMIT)
        ) u_slot (
            .clk         (clk),
            .rst         (rst),
            .launch_i    (launch_sel[g]),
            .hit_i       (bus.hit[g]),
            .move_tick_i (move_tick),
            .h_plane_i   (bus.h_my_plane),
            .v_plane_i   (bus.v_my_plane),
            .h_o         (h_w[g*COORD_W +: COORD_W]),
            .v_o         (v_w[g*COORD_W +: COORD_W]),
            .active_o    (active_w[g])
        );
    end

    assign bus.h_bullet   = h_w;
    assign bus.v_bullet   = v_w;
    assign bus.active     = active_w;
    assign bus.shot_fired = shot_q;

endmodule

// File: tb/tb_bullet_pool.sv
// Scoreboard bench for bullet_pool: stimulus queues expected snapshots tagged with
// the cycle they must appear on; a negedge monitor pops and compares them.
module tb_bullet_pool;
    import bullet_pool_pkg::*;

    localparam int N  = 4;
    localparam int CW = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bullet_pool_if #(.N_BULLETS(N), .COORD_W(CW)) bus ();

    bullet_pool #(
        .N_BULLETS (N),
        .COORD_W   (CW),
        .MOVE_DIV  (1),
        .STEP      (1),
        .TOP_LIMIT (1),
        .COOLDOWN  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        string      name;
        int         cyc;
        logic [3:0] act;
        logic       shot;
        int         slot;
        int         h;
        int         v;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input string name, input int at, input logic [3:0] act,
                             input logic shot, input int slot, input int h, input int v);
        exp_t e;
        int   idx;
        e = '{name, at, act, shot, slot, h, v};
        idx = sb.size();
        while (idx > 0 && sb[idx-1].cyc > at) idx--;
        sb.insert(idx, e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   ah, av;
        bit   ok;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e  = sb.pop_front();
            ah = 0;
            av = 0;
            if (e.slot >= 0) begin
                ah = int'(bus.h_bullet[e.slot*CW +: CW]);
                av = int'(bus.v_bullet[e.slot*CW +: CW]);
            end
            vectors++;
            ok = (e.cyc == cyc) && (bus.active === e.act) && (bus.shot_fired === e.shot);
            if (e.slot >= 0) ok = ok && (ah == e.h) && (av == e.v);
            if (!ok) begin
                miscompares++;
                $display("FAIL %s @cyc %0d: got act=%b shot=%b slot%0d=(%0d,%0d); want cyc %0d act=%b shot=%b (%0d,%0d)",
                         e.name, cyc, bus.active, bus.shot_fired, e.slot, ah, av,
                         e.cyc, e.act, e.shot, e.h, e.v);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst            = 1'b1;
        bus.fire       = 1'b0;
        bus.hit        = '0;
        bus.h_my_plane = 10'd320;
        bus.v_my_plane = 10'd400;

        // reset and idle tracking
        step(1);
        expect_at("reset", cyc + 1, 4'b0000, 1'b0, 0, 0, 0);
        step(1);
        rst = 1'b0;
        expect_at("idle_s0", cyc + 1, 4'b0000, 1'b0, 0, 320, 400);
        expect_at("idle_s3", cyc + 1, 4'b0000, 1'b0, 3, 320, 400);
        step(1);

        // single shot, key held 20 cycles, flight to the top limit
        t = cyc;
        bus.fire = 1'b1;
        expect_at("launch",   t + 1,   4'b0001, 1'b1, 0, 320, 400);
        expect_at("move1",    t + 2,   4'b0001, 1'b0, 0, 320, 399);
        expect_at("held_s1",  t + 10,  4'b0001, 1'b0, 1, 320, 400);
        expect_at("hold_end", t + 21,  4'b0001, 1'b0, 0, 320, 380);
        expect_at("at_top",   t + 400, 4'b0001, 1'b0, 0, 320, 1);
        expect_at("retired",  t + 401, 4'b0000, 1'b0, -1, 0, 0);
        expect_at("retrack",  t + 402, 4'b0000, 1'b0, 0, 320, 400);
        step(20);
        bus.fire = 1'b0;
        step(382);

        // cooldown spacing, full pool, hit+fire collision, multi-hit
        t = cyc;
        expect_at("cd_acc_s0",  t + 1,  4'b0001, 1'b1, 0, 100, 200);
        expect_at("cd_drop_2",  t + 4,  4'b0001, 1'b0, -1, 0, 0);
        expect_at("cd_acc_s1",  t + 6,  4'b0011, 1'b1, 1, 110, 200);
        expect_at("s0_moving",  t + 6,  4'b0011, 1'b1, 0, 100, 195);
        expect_at("cd_drop_1",  t + 10, 4'b0011, 1'b0, -1, 0, 0);
        expect_at("cd_acc_s2",  t + 12, 4'b0111, 1'b1, 2, 120, 200);
        expect_at("fill_s3",    t + 18, 4'b1111, 1'b1, 3, 130, 200);
        expect_at("full_drop",  t + 24, 4'b1111, 1'b0, -1, 0, 0);
        expect_at("hit_fire",   t + 26, 4'b1101, 1'b0, -1, 0, 0);
        expect_at("refill_s1",  t + 28, 4'b1111, 1'b1, 1, 200, 300);
        expect_at("multi_hit",  t + 30, 4'b0101, 1'b0, -1, 0, 0);
        expect_at("s2_moving",  t + 30, 4'b0101, 1'b0, 2, 120, 182);
        expect_at("s1_retrack", t + 31, 4'b0101, 1'b0, 1, 200, 300);
        for (int k = 0; k <= 30; k++) begin
            bus.fire       = (k inside {0, 3, 5, 9, 11, 17, 23, 25, 27});
            bus.hit        = (k == 25) ? 4'b0010 : (k == 29) ? 4'b1010 : 4'b0000;
            bus.h_my_plane = (k < 5) ? 10'd100 : (k < 11) ? 10'd110 : (k < 17) ? 10'd120 :
                             (k < 27) ? 10'd130 : 10'd200;
            bus.v_my_plane = (k < 27) ? 10'd200 : 10'd300;
            step(1);
        end

        // reset mid-flight, fire right after reset, hit on an idle slot
        t = cyc;
        expect_at("rst_clear",  t + 1,  4'b0000, 1'b0, 0, 0, 0);
        expect_at("post_rst",   t + 2,  4'b0001, 1'b1, 0, 50, 60);
        expect_at("second_s1",  t + 7,  4'b0011, 1'b1, 1, 50, 60);
        expect_at("pre_rst",    t + 8,  4'b0011, 1'b0, -1, 0, 0);
        expect_at("midflight",  t + 9,  4'b0000, 1'b0, 1, 0, 0);
        expect_at("relaunch",   t + 10, 4'b0001, 1'b1, 0, 50, 60);
        expect_at("idle_hit",   t + 11, 4'b0001, 1'b0, 2, 50, 60);
        for (int k = 0; k <= 11; k++) begin
            rst            = (k inside {0, 8});
            bus.fire       = (k inside {1, 6, 9});
            bus.hit        = (k == 10) ? 4'b0100 : 4'b0000;
            bus.h_my_plane = 10'd50;
            bus.v_my_plane = 10'd60;
            step(1);
        end
        rst = 1'b0;
        step(2);

        if (sb.size() != 0) begin
            $display("FAIL pending: %0d expectations never compared, want 0", sb.size());
            miscompares += sb.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
